// File: rtl/alu_pkg.sv
// Shared opcode encodings and multiplier FSM state type for the sequential ALU.
package alu_pkg;

    localparam int unsigned OP_PASS = 0;
    localparam int unsigned OP_ADD  = 1;
    localparam int unsigned OP_SUB  = 2;
    localparam int unsigned OP_AND  = 3;
    localparam int unsigned OP_OR   = 4;
    localparam int unsigned OP_XOR  = 5;
    localparam int unsigned OP_NOT  = 6;
    localparam int unsigned OP_SHL  = 7;
    localparam int unsigned OP_SHR  = 8;
    localparam int unsigned OP_MUL  = 9;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } mul_state_e;

endpackage

// File: rtl/alu_seq_if.sv
// ALU request/result bus.
//  master: drives operands, opcode and alu_ena; observes result, flags, busy, done.
//  slave : the ALU side.
interface alu_seq_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned OPW   = 4
) ();

    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] accum;
    logic [OPW-1:0]   opcode;
    logic             alu_ena;
    logic [WIDTH-1:0] alu_out;
    logic             zero;
    logic             carry;
    logic             neg;
    logic             busy;
    logic             done;

    modport master (
        output data, accum, opcode, alu_ena,
        input  alu_out, zero, carry, neg, busy, done
    );

    modport slave (
        input  data, accum, opcode, alu_ena,
        output alu_out, zero, carry, neg, busy, done
    );

endinterface

// File: rtl/alu_mul_seq.sv
// Shift-add unsigned multiplier, one multiplier bit per cycle.
//  clk, rst   : clock, synchronous active-high reset (aborts a running multiply)
//  start      : load a/b and begin; honoured only while idle
//  a, b       : multiplicand / multiplier
//  busy       : multiply in progress
//  last_c     : final iteration happens at the coming edge
//  product_c  : full 2*WIDTH product, valid while last_c is high
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               last_c,
    output logic [2*WIDTH-1:0] product_c
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam int unsigned PW    = 2 * WIDTH;

    mul_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [PW-1:0]    prod_q, prod_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            prod_q   <= '0;
            mplier_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            prod_q   <= prod_d;
            mplier_q <= mplier_d;
        end
    end

    // Next-state and iteration datapath.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        mplier_d = mplier_q;
        last_c   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_MUL;
                    cnt_d    = '0;
                    mcand_d  = PW'(a);
                    mplier_d = b;
                    prod_d   = '0;
                end
            end
            S_MUL: begin
                if (mplier_q[0]) begin
                    prod_d = prod_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    last_c  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Only meaningful with last_c: includes the final partial product.
        product_c = prod_d;
    end

    assign busy = (state_q == S_MUL);

endmodule

// File: rtl/alu_seq.sv
// Accumulator ALU with registered result, zero/carry/negative flags and a
// multi-cycle multiply behind a start/busy/done handshake.
//  clk, rst : clock, synchronous active-high reset
//  bus      : slave side of alu_seq_if (operands, opcode, alu_ena in;
//             alu_out, zero, carry, neg, busy, done out)
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned OPW   = 4
) (
    input  logic       clk,
    input  logic       rst,
    alu_seq_if.slave   bus
);

    logic [WIDTH-1:0]   out_q;
    logic               zero_q, carry_q, neg_q, done_q;

    logic               mul_busy, mul_last_c;
    logic [2*WIDTH-1:0] product_c;

    logic               accept_c, op_mul_c;
    logic [WIDTH:0]     sum_c, diff_c;
    logic [WIDTH-1:0]   res_c;
    logic               cry_c, wr_c;
    logic [WIDTH-1:0]   wr_val_c;
    logic               wr_cry_c, wr_en_c, done_d_c;

    assign accept_c = bus.alu_ena && !mul_busy;
    assign op_mul_c = (bus.opcode == OPW'(OP_MUL));

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk       (clk),
        .rst       (rst),
        .start     (accept_c && op_mul_c),
        .a         (bus.accum),
        .b         (bus.data),
        .busy      (mul_busy),
        .last_c    (mul_last_c),
        .product_c (product_c)
    );

    assign sum_c  = {1'b0, bus.accum} + {1'b0, bus.data};
    assign diff_c = {1'b0, bus.accum} - {1'b0, bus.data};

    // Single-cycle opcode decode; wr_c low for MUL and undefined opcodes.
    always_comb begin
        res_c = out_q;
        cry_c = 1'b0;
        wr_c  = 1'b1;
        case (bus.opcode)
            OPW'(OP_PASS): res_c = bus.data;
            OPW'(OP_ADD):  begin res_c = sum_c[WIDTH-1:0];  cry_c = sum_c[WIDTH];  end
            OPW'(OP_SUB):  begin res_c = diff_c[WIDTH-1:0]; cry_c = diff_c[WIDTH]; end
            OPW'(OP_AND):  res_c = bus.accum & bus.data;
            OPW'(OP_OR):   res_c = bus.accum | bus.data;
            OPW'(OP_XOR):  res_c = bus.accum ^ bus.data;
            OPW'(OP_NOT):  res_c = ~bus.accum;
            OPW'(OP_SHL):  begin res_c = {bus.accum[WIDTH-2:0], 1'b0}; cry_c = bus.accum[WIDTH-1]; end
            OPW'(OP_SHR):  begin res_c = {1'b0, bus.accum[WIDTH-1:1]}; cry_c = bus.accum[0]; end
            default:       wr_c = 1'b0;
        endcase
    end

    // Write-back select: multiply completion and accepts are mutually exclusive via busy.
    always_comb begin
        wr_en_c  = 1'b0;
        wr_val_c = product_c[WIDTH-1:0];
        wr_cry_c = |product_c[2*WIDTH-1:WIDTH];
        done_d_c = mul_last_c;
        if (mul_last_c) begin
            wr_en_c = 1'b1;
        end else if (accept_c && !op_mul_c) begin
            wr_en_c  = wr_c;
            wr_val_c = res_c;
            wr_cry_c = cry_c;
            done_d_c = 1'b1;
        end
    end

    // Result, flag and done registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q   <= '0;
            zero_q  <= 1'b1;
            carry_q <= 1'b0;
            neg_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= done_d_c;
            if (wr_en_c) begin
                out_q   <= wr_val_c;
                zero_q  <= (wr_val_c == '0);
                carry_q <= wr_cry_c;
                neg_q   <= wr_val_c[WIDTH-1];
            end
        end
    end

    assign bus.alu_out = out_q;
    assign bus.zero    = zero_q;
    assign bus.carry   = carry_q;
    assign bus.neg     = neg_q;
    assign bus.done    = done_q;
    assign bus.busy    = mul_busy;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8): directed vector table, multi-cycle
// corner sequences and random ops against an arithmetic reference model.
module tb_alu_seq;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned OPW   = 4;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    // Reference model state: last written result and carry.
    int m_out;
    int m_c;
    int m_lat;

    alu_seq_if #(.WIDTH(WIDTH), .OPW(OPW)) bus ();

    alu_seq #(.WIDTH(WIDTH), .OPW(OPW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int op;
        int a;
        int d;
        int out;
        int c;
        int z;
        int n;
        int lat;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // Arithmetic model of one operation; lat is accept-to-done in cycles.
    task automatic model_apply(input int op, input int a, input int d);
        int r;
        int c;
        int p;
        r = m_out;
        c = m_c;
        m_lat = 1;
        case (op)
            0: begin r = d; c = 0; end
            1: begin p = a + d; r = p % 256; c = (p > 255) ? 1 : 0; end
            2: begin r = (a - d + 256) % 256; c = (a < d) ? 1 : 0; end
            3: begin r = a & d; c = 0; end
            4: begin r = a | d; c = 0; end
            5: begin r = a ^ d; c = 0; end
            6: begin r = 255 - a; c = 0; end
            7: begin r = (a * 2) % 256; c = (a >= 128) ? 1 : 0; end
            8: begin r = a / 2; c = a % 2; end
            9: begin p = a * d; r = p % 256; c = (p > 255) ? 1 : 0; m_lat = WIDTH + 1; end
            default: ;
        endcase
        m_out = r;
        m_c   = c;
    endtask

    task automatic issue(input int op, input int a, input int d);
        @(negedge clk);
        bus.opcode  = 4'(op);
        bus.accum   = 8'(a);
        bus.data    = 8'(d);
        bus.alu_ena = 1'b1;
        @(posedge clk);
        #1;
        bus.alu_ena = 1'b0;
    endtask

    // Called right after the accept edge; returns cycles until done is seen.
    task automatic wait_done(output int lat);
        lat = 1;
        while (bus.done !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic check_outputs(input string tag, input int out, input int c,
                                 input int z, input int n);
        chk({tag, ".out"},  32'(bus.alu_out), 32'(out));
        chk({tag, ".carry"}, 32'(bus.carry),  32'(c));
        chk({tag, ".zero"},  32'(bus.zero),   32'(z));
        chk({tag, ".neg"},   32'(bus.neg),    32'(n));
    endtask

    vec_t vecs[$];

    initial begin
        int lat;
        int ndone;
        int nbusy;
        int done_at;

        checks   = 0;
        failures = 0;
        m_out    = 0;
        m_c      = 0;
        m_lat    = 1;
        rst         = 1'b1;
        bus.alu_ena = 1'b0;
        bus.opcode  = '0;
        bus.accum   = '0;
        bus.data    = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset", 0, 0, 1, 0);
        chk("reset.busy", 32'(bus.busy), 32'd0);
        chk("reset.done", 32'(bus.done), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors with hand-derived expectations
        vecs.push_back('{1, 'hF0, 'h20, 'h10, 1, 0, 0, 1});
        vecs.push_back('{2, 'h05, 'h05, 'h00, 0, 1, 0, 1});
        vecs.push_back('{2, 'h03, 'h05, 'hFE, 1, 0, 1, 1});
        vecs.push_back('{7, 'h81, 'h00, 'h02, 1, 0, 0, 1});
        vecs.push_back('{8, 'h81, 'h00, 'h40, 1, 0, 0, 1});
        vecs.push_back('{3, 'hF0, 'h3C, 'h30, 0, 0, 0, 1});
        vecs.push_back('{4, 'hF0, 'h3C, 'hFC, 0, 0, 1, 1});
        vecs.push_back('{5, 'hF0, 'h3C, 'hCC, 0, 0, 1, 1});
        vecs.push_back('{6, 'h0F, 'h00, 'hF0, 0, 0, 1, 1});
        vecs.push_back('{0, 'h00, 'h80, 'h80, 0, 0, 1, 1});
        vecs.push_back('{9, 'h10, 'h11, 'h10, 1, 0, 0, 9});
        vecs.push_back('{9, 'h0C, 'h0A, 'h78, 0, 0, 0, 9});
        vecs.push_back('{15, 'hAA, 'h55, 'h78, 0, 0, 0, 1});
        vecs.push_back('{1, 'hFF, 'h01, 'h00, 1, 1, 0, 1});
        vecs.push_back('{10, 'h12, 'h34, 'h00, 1, 1, 0, 1});
        vecs.push_back('{9, 'hFF, 'hFF, 'h01, 1, 0, 0, 9});

        for (int i = 0; i < vecs.size(); i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            issue(vecs[i].op, vecs[i].a, vecs[i].d);
            model_apply(vecs[i].op, vecs[i].a, vecs[i].d);
            wait_done(lat);
            chk({tag, ".lat"}, 32'(lat), 32'(vecs[i].lat));
            check_outputs(tag, vecs[i].out, vecs[i].c, vecs[i].z, vecs[i].n);
            @(posedge clk);
            #1;
            chk({tag, ".done_pulse"}, 32'(bus.done), 32'd0);
        end

        // ALU_ENA with ADD pulsed mid-multiply and operands changing: ignored
        issue(9, 'h0C, 'h0A);
        model_apply(9, 'h0C, 'h0A);
        chk("ign.busy_at_accept", 32'(bus.busy), 32'd1);
        nbusy   = 1;
        ndone   = 0;
        done_at = -1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            bus.opcode  = 4'd1;
            bus.accum   = 8'($urandom_range(0, 255));
            bus.data    = 8'($urandom_range(0, 255));
            bus.alu_ena = (k == 3);
            @(posedge clk);
            #1;
            if (bus.busy === 1'b1) nbusy++;
            if (bus.done === 1'b1) begin
                ndone++;
                if (done_at < 0) done_at = k;
            end
        end
        bus.alu_ena = 1'b0;
        chk("ign.busy_cycles", 32'(nbusy), 32'(WIDTH));
        chk("ign.done_count", 32'(ndone), 32'd1);
        chk("ign.done_cycle", 32'(done_at), 32'(WIDTH));
        check_outputs("ign", 'h78, 0, 0, 0);

        // Reset in the middle of a multiply aborts it
        issue(9, 'h10, 'h11);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        m_out = 0;
        m_c   = 0;
        check_outputs("rstmul", 0, 0, 1, 0);
        chk("rstmul.busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        rst   = 1'b0;
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) ndone++;
        end
        chk("rstmul.no_done", 32'(ndone), 32'd0);
        check_outputs("rstmul.hold", 0, 0, 1, 0);

        // Random ops, issued back-to-back in the done cycle
        for (int i = 0; i < 60; i++) begin
            int op;
            int a;
            int d;
            string tag;
            op  = $urandom_range(0, 15);
            a   = $urandom_range(0, 255);
            d   = $urandom_range(0, 255);
            tag = $sformatf("rnd%0d_op%0d", i, op);
            issue(op, a, d);
            model_apply(op, a, d);
            wait_done(lat);
            chk({tag, ".lat"}, 32'(lat), 32'(m_lat));
            check_outputs(tag, m_out, m_c, (m_out == 0) ? 1 : 0, (m_out >= 128) ? 1 : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
